// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and limits for the RC4 keystream consumer.
package rc4_pkg;
   typedef logic [7:0] byte_t;
   typedef enum logic [2:0] {IDLE, WAIT_KEY, DROP, RUN, DRAIN} state_e;
   localparam int DROP_N_MAX = 1023;
endpackage

// File: rtl/rc4_ks_fifo.sv
// rc4_ks_fifo: synchronous byte FIFO holding keystream bytes ahead of use.
module rc4_ks_fifo
   import rc4_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        push,
   input  logic        pop,
   input  logic [7:0]  din,
   output logic [7:0]  head,
   output logic [AW:0] count,
   output logic        empty,
   output logic        full
);
   byte_t mem_q [DEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [AW:0] cnt_q;
   logic do_push, do_pop;
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head = mem_q[rd_q];
   assign count = cnt_q;
   assign empty = cnt_q == '0;
   assign full = cnt_q == (AW+1)'(DEPTH);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q <= '0;
         wr_q <= '0;
         cnt_q <= '0;
      end else if (clr) begin
         rd_q <= '0;
         wr_q <= '0;
         cnt_q <= '0;
      end else begin
         rd_q <= rd_q + AW'(do_pop);
         wr_q <= wr_q + AW'(do_push);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end
endmodule

// File: rtl/rc4_stream_xor.sv
// rc4_stream_xor: requests RC4 keystream under a credit limit, optionally drops
// the first DROP_N bytes, and XORs the rest onto the incoming byte stream.
module rc4_stream_xor
   import rc4_pkg::*;
#(
   parameter int KS_DEPTH = 4,
   parameter int DROP_N = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       ks_ready,
   output logic       ks_req,
   input  logic       ks_valid,
   input  logic [7:0] ks_data,
   input  logic       din_valid,
   output logic       din_ready,
   input  logic [7:0] din_data,
   input  logic       din_last,
   output logic       dout_valid,
   input  logic       dout_ready,
   output logic [7:0] dout_data,
   output logic       dout_last,
   output logic       busy,
   output logic       done,
   output logic       ks_err
);
   localparam int CW = $clog2(KS_DEPTH) + 1;
   localparam int DW = $clog2(DROP_N_MAX + 1);
   state_e state_q;
   logic [CW-1:0] out_q, out_d, fifo_count;
   logic [DW-1:0] drop_cnt_q;
   logic [CW:0] credits;
   logic [DW:0] drop_issued;
   byte_t fifo_head, dout_data_q;
   logic fifo_empty, fifo_full, ks_ok, ks_stray, push, out_free, fire, drain_done;
   logic dout_valid_q, dout_last_q, done_q, ks_err_q;
   // drop requests stop once accepted plus in-flight bytes cover DROP_N
   assign credits = {1'b0, fifo_count} + {1'b0, out_q};
   assign drop_issued = {1'b0, drop_cnt_q} + (DW+1)'(out_q);
   assign ks_req = (state_q == RUN || (state_q == DROP && drop_issued < (DW+1)'(DROP_N)))
                   && credits < (CW+1)'(KS_DEPTH);
   assign ks_ok = ks_valid && out_q != '0;
   assign ks_stray = ks_valid && out_q == '0;
   assign push = ks_ok && state_q == RUN && !fifo_full;
   assign out_free = !dout_valid_q || dout_ready;
   assign din_ready = state_q == RUN && !fifo_empty && out_free;
   assign fire = din_valid && din_ready;
   assign drain_done = state_q == DRAIN && out_q == '0 && out_free;
   assign out_d = out_q + CW'(ks_req) - CW'(ks_ok);
   assign dout_valid = dout_valid_q;
   assign dout_data = dout_data_q;
   assign dout_last = dout_last_q;
   assign busy = state_q != IDLE;
   assign done = done_q;
   assign ks_err = ks_err_q;
   rc4_ks_fifo #(.DEPTH(KS_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (drain_done),
      .push  (push),
      .pop   (fire),
      .din   (ks_data),
      .head  (fifo_head),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         out_q <= '0;
         drop_cnt_q <= '0;
         dout_valid_q <= 1'b0;
         dout_data_q <= '0;
         dout_last_q <= 1'b0;
         done_q <= 1'b0;
         ks_err_q <= 1'b0;
      end else begin
         out_q <= out_d;
         done_q <= 1'b0;
         if (ks_stray) ks_err_q <= 1'b1;
         if (fire) begin
            dout_valid_q <= 1'b1;
            dout_data_q <= din_data ^ fifo_head;
            dout_last_q <= din_last;
         end else if (dout_ready) begin
            dout_valid_q <= 1'b0;
         end
         case (state_q)
            IDLE: if (start) begin
               state_q <= WAIT_KEY;
               drop_cnt_q <= '0;
            end
            WAIT_KEY: if (ks_ready) state_q <= DROP_N > 0 ? DROP : RUN;
            DROP: begin
               if (ks_ok) drop_cnt_q <= drop_cnt_q + 1'b1;
               if (drop_cnt_q == DW'(DROP_N) && out_q == '0) state_q <= RUN;
            end
            RUN: if (fire && din_last) state_q <= DRAIN;
            DRAIN: if (drain_done) begin
               state_q <= IDLE;
               done_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/rc4_stream_xor.md
Name: rc4_stream_xor

Overview:
- Consumer end of the RC4 keystream interface. Requests keystream bytes from the RC4 core, buffers them, and XORs them with an incoming plaintext or ciphertext byte stream. Encrypt and decrypt are the same operation.
- Sits between the RC4 keystream core and the byte-stream datapath.
- Supports an optional RC4-drop of the first DROP_N keystream bytes.

Parameters:
KS_DEPTH, 4, keystream FIFO depth, also the request credit limit (power of 2, >=2)
DROP_N, 0, keystream bytes discarded after key setup before any data is processed (0..1023)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, begin a session; ignored unless IDLE
ks_ready  in  1  RC4 core key setup complete, PRGA running
ks_req  out  1  one-cycle pulse, request one keystream byte
ks_valid  in  1  one-cycle pulse, keystream byte returned, in request order
ks_data  in  8  keystream byte
din_valid  in  1  input byte valid
din_ready  out  1  input byte accepted when valid&ready
din_data  in  8  input byte
din_last  in  1  final byte of session
dout_valid  out  1  output byte valid
dout_ready  in  1  downstream accepts
dout_data  out  8  din_data XOR keystream
dout_last  out  1  copy of din_last
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at session end
ks_err  out  1  sticky: ks_valid while no request outstanding; cleared only by reset

Behaviour:
- Reset (async, rst_n=0): state IDLE; FIFO and all counters cleared; ks_req=0, din_ready=0, dout_valid=0, dout_data=0, dout_last=0, busy=0, done=0, ks_err=0.
- Credits: credits = fifo_count + outstanding.
  - ks_req pulses for one cycle when state is DROP or RUN and credits < KS_DEPTH. At most one request per cycle.
  - outstanding increments on ks_req and decrements on ks_valid. Simultaneous ks_req and ks_valid leave outstanding unchanged.
- States:
  - IDLE: start -> WAIT_KEY.
  - WAIT_KEY: no requests. When ks_ready=1 -> DROP if DROP_N>0, else RUN.
  - DROP: ks_valid bytes are discarded, not pushed to the FIFO. drop_cnt counts accepted bytes. Once drop_cnt reaches DROP_N, no further drop requests are issued. When all dropped bytes have arrived (outstanding=0) -> RUN.
  - RUN: ks_valid bytes are pushed to the FIFO.
    - din_ready = fifo_nonempty & (!dout_valid | dout_ready).
    - On a din handshake: pop the FIFO; dout_data <= din_data ^ fifo_head; dout_last <= din_last; dout_valid <= 1. Output appears the cycle after the handshake (latency 1).
    - Handshake with din_last=1 -> DRAIN.
  - DRAIN: no new requests; din_ready=0. Bytes still arriving on ks_valid are discarded. When outstanding=0 and (!dout_valid | dout_ready): FIFO cleared, done=1 for one cycle -> IDLE.
- Output register: dout_valid is cleared on dout_ready when no new handshake occurs in the same cycle. Full throughput is 1 byte/cycle when ks_valid keeps up.
- Backpressure: while dout_valid=1 and dout_ready=0, dout_data and dout_last hold, din_ready=0, and requests stop once credits reach KS_DEPTH.
- Simultaneous FIFO push and pop in one cycle is allowed; count is unchanged.
- The FIFO never overflows by construction. ks_valid with outstanding=0 sets ks_err and the byte is dropped.
- start outside IDLE is ignored. Keystream is not retained across sessions; each session requires a fresh key setup.
- Reset mid-session aborts immediately to the reset values above.
- Widths: outstanding and fifo_count are clog2(KS_DEPTH)+1 bits; drop_cnt is 10 bits. All XOR is 8-bit with no carries.

Decomposition:
- Shared package rc4_pkg: byte_t (8-bit), state enum (IDLE, WAIT_KEY, DROP, RUN, DRAIN), DROP_N maximum constant.
- One sub-module: rc4_ks_fifo (synchronous byte FIFO: push, pop, count, empty, full).

Test Plan:
- Reset mid-RUN -> all outputs 0 in the same cycle; after release, busy=0 and start is accepted.
- DROP_N=0, keystream 0x5A,0x3C; din 0x00, 0xFF(last) -> dout 0x5A, then 0xC3 with dout_last=1; done one cycle after the final output is accepted.
- KS_DEPTH=4, dout_ready held 0 for 6 cycles -> exactly 4 credits outstanding or buffered, ks_req stops, dout_data held stable, nothing lost after release.
- DROP_N=3, keystream 0x11,0x22,0x33,0x44; din 0xF0 -> dout 0xB4 (0xF0^0x44).
- Keystream latency alternating 1 and 5 cycles, 16-byte message -> output equals reference XOR in order; din_last waits for outstanding=0 before done; busy falls with done.
- ks_valid injected in IDLE -> ks_err=1, stays set through the next session; FIFO empty.
